// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle for the N-channel registered mux: input channels, select
// controls and the single output stream.
interface mux_nto1_rr_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
);
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SELW-1:0] out_sel;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-channel registered merge mux with manual select or round-robin arbitration.
// One output register; loads when empty or being drained in the same cycle.
module mux_nto1_rr #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nto1_rr_if.slave  bus
);

    logic [W-1:0]    data_q;
    logic            valid_q;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] ptr;

    logic            load_en;
    logic            gnt_vld;
    logic [SELW-1:0] gnt;
    logic            xfer;
    int              idx;

    assign load_en = !valid_q || bus.out_ready;

    // Round-robin scans from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (bus.in_valid[SELW'(idx)]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(idx);
                end
            end
        end
    end

    assign xfer = rst_n && gnt_vld && load_en;

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            data_q  <= bus.in_data[int'(gnt)*W +: W];
            sel_q   <= gnt;
            valid_q <= 1'b1;
            if (bus.mode) ptr <= (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel   = sel_q;

endmodule
